player_move_ctrl: RTL and testbench

- Upstream of the 16x16 IC-chip player sprite renderer; produces its player_x/player_y screen position.
- Accepts a "move N tiles" command via valid/ready handshake.
- Walks the player tile-by-tile along a serpentine board path with per-frame pixel interpolation and a short pause on each tile.
- Reports the current tile, busy, and a one-cycle completion pulse to game logic.

---
 rtl/player_move_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Player sprite path controller: walks the sprite tile-by-tile along a serpentine board
// path with per-frame interpolation. Define PLAYER_HOP_EN to add a small hop mid-step.
//
// state | meaning
// IDLE  | waiting for a move command (move_ready high)
// LOAD  | select next tile along the path and latch its screen target
// MOVE  | step toward the target on each frame_tick
// PAUSE | hold on the arrived tile for PAUSE_FRAMES frame ticks
// DONE  | one-cycle completion pulse, then back to IDLE

module player_move_ctrl #(
    parameter int BOARD_X0     = 64,
    parameter int BOARD_Y0     = 48,
    parameter int TILE_W       = 32,
    parameter int COLS         = 8,
    parameter int ROWS         = 4,
    parameter int STEP_PX      = 4,
    parameter int PAUSE_FRAMES = 8,
    localparam int NUM_TILES   = COLS * ROWS,
    localparam int TW          = $clog2(NUM_TILES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          move_valid,
    output logic          move_ready,
    input  logic [3:0]    move_steps,
    output logic [9:0]    player_x,
    output logic [9:0]    player_y,
    output logic [TW-1:0] cur_tile,
    output logic          busy,
    output logic          move_done
);

    localparam int              PW         = $clog2(PAUSE_FRAMES + 1);
    localparam int              INSET      = (TILE_W - 16) / 2;
    localparam logic [9:0]      STEP       = 10'(STEP_PX);
    localparam logic [9:0]      HOME_X     = 10'(BOARD_X0 + INSET);
    localparam logic [9:0]      HOME_Y     = 10'(BOARD_Y0 + INSET);
    localparam logic [TW-1:0]   LAST_TILE  = TW'(NUM_TILES - 1);
    localparam logic [PW-1:0]   PAUSE_LOAD = PW'(PAUSE_FRAMES);
    localparam logic [PW-1:0]   PAUSE_LAST = PW'(1);

    if (TILE_W < 16) begin : g_chk_tile_w
        $error("player_move_ctrl: TILE_W must be >= 16");
    end
    if (TILE_W % STEP_PX != 0) begin : g_chk_step
        $error("player_move_ctrl: STEP_PX must divide TILE_W");
    end
    if (PAUSE_FRAMES < 1) begin : g_chk_pause
        $error("player_move_ctrl: PAUSE_FRAMES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [9:0]    path_x, path_y;
    logic [9:0]    tgt_x, tgt_y;
    logic [9:0]    new_x, new_y;
    logic [TW-1:0] next_tile;
    logic [TW-1:0] succ_tile;
    logic [3:0]    remaining;
    logic [PW-1:0] pause_cnt;
    logic          wrap_q;
    logic          arrive;

    // Odd rows run right-to-left so consecutive tiles stay adjacent.
    function automatic logic [9:0] tile_x(input logic [TW-1:0] idx);
        int r, c, col;
        r   = int'(idx) / COLS;
        c   = int'(idx) % COLS;
        col = (r % 2 == 0) ? c : COLS - 1 - c;
        return 10'(BOARD_X0 + col * TILE_W + INSET);
    endfunction

    function automatic logic [9:0] tile_y(input logic [TW-1:0] idx);
        int r;
        r = int'(idx) / COLS;
        return 10'(BOARD_Y0 + r * TILE_W + INSET);
    endfunction

    assign succ_tile = (cur_tile == LAST_TILE) ? '0 : cur_tile + TW'(1);

    // Only one axis differs between path neighbours; the wrap step jumps straight there.
    always_comb begin
        new_x = path_x;
        new_y = path_y;
        if (wrap_q) begin
            new_x = tgt_x;
            new_y = tgt_y;
        end else if (path_x != tgt_x) begin
            new_x = (tgt_x > path_x) ? path_x + STEP : path_x - STEP;
        end else if (path_y != tgt_y) begin
            new_y = (tgt_y > path_y) ? path_y + STEP : path_y - STEP;
        end
    end

    assign arrive = (new_x == tgt_x) && (new_y == tgt_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        move_ready = 1'b0;
        busy       = 1'b0;
        move_done  = 1'b0;
        case (state)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    state_nx = (move_steps == 4'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                state_nx = S_MOVE;
            end
            S_MOVE: begin
                busy = 1'b1;
                if (frame_tick && arrive) begin
                    state_nx = S_PAUSE;
                end
            end
            S_PAUSE: begin
                busy = 1'b1;
                if (frame_tick && pause_cnt == PAUSE_LAST) begin
                    state_nx = (remaining != 4'd0) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                move_done = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            path_x    <= HOME_X;
            path_y    <= HOME_Y;
            tgt_x     <= HOME_X;
            tgt_y     <= HOME_Y;
            cur_tile  <= '0;
            next_tile <= '0;
            remaining <= 4'd0;
            pause_cnt <= '0;
            wrap_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (move_valid && move_steps != 4'd0) begin
                        remaining <= move_steps;
                    end
                end
                S_LOAD: begin
                    next_tile <= succ_tile;
                    tgt_x     <= tile_x(succ_tile);
                    tgt_y     <= tile_y(succ_tile);
                    wrap_q    <= (cur_tile == LAST_TILE);
                end
                S_MOVE: begin
                    if (frame_tick) begin
                        path_x <= new_x;
                        path_y <= new_y;
                        if (arrive) begin
                            cur_tile  <= next_tile;
                            remaining <= remaining - 4'd1;
                            pause_cnt <= PAUSE_LOAD;
                        end
                    end
                end
                S_PAUSE: begin
                    if (frame_tick) begin
                        pause_cnt <= pause_cnt - PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign player_x = path_x;

`ifdef PLAYER_HOP_EN
    logic [9:0] progress;
    logic       hop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            progress <= 10'd0;
        end else if (state == S_LOAD) begin
            progress <= 10'd0;
        end else if (state == S_MOVE && frame_tick) begin
            progress <= progress + STEP;
        end
    end

    assign hop = (state == S_MOVE) && !wrap_q &&
                 (progress >= 10'(TILE_W / 4)) && (progress < 10'(3 * TILE_W / 4));
    assign player_y = hop ? path_y - 10'd3 : path_y;
`else
    assign player_y = path_y;
`endif

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: randomized frame-tick spacing and command
// lengths, checked against a tile-geometry and linear-interpolation reference model.

module tb_player_move_ctrl;

    localparam int BOARD_X0     = 64;
    localparam int BOARD_Y0     = 48;
    localparam int TILE_W       = 32;
    localparam int COLS         = 8;
    localparam int ROWS         = 4;
    localparam int STEP_PX      = 4;
    localparam int PAUSE_FRAMES = 8;
    localparam int NT           = COLS * ROWS;
    localparam int TW           = $clog2(NT);
    localparam int INSET        = (TILE_W - 16) / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          move_valid = 1'b0;
    logic [3:0]    move_steps = 4'd0;
    logic          move_ready;
    logic [9:0]    player_x, player_y;
    logic [TW-1:0] cur_tile;
    logic          busy, move_done;

    int n_checks = 0;
    int n_fail   = 0;
    int model_tile = 0;

    player_move_ctrl #(
        .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0), .TILE_W(TILE_W), .COLS(COLS),
        .ROWS(ROWS), .STEP_PX(STEP_PX), .PAUSE_FRAMES(PAUSE_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_valid(move_valid),
        .move_ready(move_ready), .move_steps(move_steps), .player_x(player_x),
        .player_y(player_y), .cur_tile(cur_tile), .busy(busy), .move_done(move_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ox(input int i);
        int r, c;
        r = i / COLS;
        c = i % COLS;
        if (r % 2 == 1) c = COLS - 1 - c;
        return BOARD_X0 + c * TILE_W + INSET;
    endfunction

    function automatic int oy(input int i);
        return BOARD_Y0 + (i / COLS) * TILE_W + INSET;
    endfunction

    // One frame_tick pulse after 1..3 quiet cycles; returns at the negedge after it.
    task automatic tick();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic issue(input int steps, input bit hold);
        int w;
        w = 0;
        while (move_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: move_ready=%b expected 1", move_ready);
        end
        move_valid = 1'b1;
        move_steps = 4'(steps);
        @(posedge clk);
        @(negedge clk);
        if (!hold) move_valid = 1'b0;
    endtask

    // Starts at the negedge following the accepting edge; ends on the IDLE cycle after DONE.
    task automatic walk(input int steps);
        int from, to, fx, fy, tx, ty, nmv, ex, ey;
        bit wrap, last;
        n_checks++;
        if (busy !== (steps != 0) || move_done !== (steps == 0)) begin
            n_fail++;
            $display("FAIL accept: busy=%b move_done=%b expected busy=%b move_done=%b",
                     busy, move_done, steps != 0, steps == 0);
        end
        if (steps == 0) begin
            n_checks++;
            if (player_x !== 10'(ox(model_tile)) || player_y !== 10'(oy(model_tile)) ||
                cur_tile !== TW'(model_tile)) begin
                n_fail++;
                $display("FAIL zero_cmd_pos: x=%0d y=%0d tile=%0d expected %0d %0d %0d",
                         player_x, player_y, cur_tile, ox(model_tile), oy(model_tile), model_tile);
            end
        end
        for (int s = 0; s < steps; s++) begin
            from = model_tile;
            to   = (from + 1) % NT;
            fx = ox(from); fy = oy(from); tx = ox(to); ty = oy(to);
            wrap = (to == 0);
            nmv  = wrap ? 1 : TILE_W / STEP_PX;
            for (int k = 1; k <= nmv; k++) begin
                tick();
                ex = wrap ? tx : fx + (tx - fx) * k / nmv;
                ey = wrap ? ty : fy + (ty - fy) * k / nmv;
`ifdef PLAYER_HOP_EN
                if (!wrap && k < nmv && STEP_PX * k >= TILE_W / 4 && STEP_PX * k < 3 * TILE_W / 4)
                    ey -= 3;
`endif
                n_checks++;
                if (player_x !== 10'(ex) || player_y !== 10'(ey)) begin
                    n_fail++;
                    $display("FAIL move_pos tile %0d->%0d tick %0d: x=%0d y=%0d expected %0d %0d",
                             from, to, k, player_x, player_y, ex, ey);
                end
                n_checks++;
                if (cur_tile !== TW'(k == nmv ? to : from) || busy !== 1'b1 ||
                    move_done !== 1'b0 || move_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL move_status tick %0d: tile=%0d busy=%b done=%b ready=%b expected %0d 1 0 0",
                             k, cur_tile, busy, move_done, move_ready, k == nmv ? to : from);
                end
            end
            model_tile = to;
            for (int p = 1; p <= PAUSE_FRAMES; p++) begin
                tick();
                last = (s == steps - 1) && (p == PAUSE_FRAMES);
                n_checks++;
                if (player_x !== 10'(tx) || player_y !== 10'(ty) || cur_tile !== TW'(to)) begin
                    n_fail++;
                    $display("FAIL pause_pos tile %0d pause %0d: x=%0d y=%0d tile=%0d expected %0d %0d %0d",
                             to, p, player_x, player_y, cur_tile, tx, ty, to);
                end
                n_checks++;
                if (move_done !== last || busy !== !last) begin
                    n_fail++;
                    $display("FAIL pause_status pause %0d: done=%b busy=%b expected %b %b",
                             p, move_done, busy, last, !last);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (move_done !== 1'b0 || busy !== 1'b0 || move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b ready=%b expected 0 0 1",
                     move_done, busy, move_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (player_x !== 10'(ox(0)) || player_y !== 10'(oy(0)) || cur_tile !== '0 ||
            move_ready !== 1'b1 || busy !== 1'b0 || move_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: x=%0d y=%0d tile=%0d ready=%b busy=%b done=%b expected 72 56 0 1 0 0",
                     player_x, player_y, cur_tile, move_ready, busy, move_done);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (player_x !== 10'd72 || player_y !== 10'd56 || cur_tile !== '0 ||
            move_ready !== 1'b1 || busy !== 1'b0 || move_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: x=%0d y=%0d tile=%0d ready=%b busy=%b done=%b expected 72 56 0 1 0 0",
                     player_x, player_y, cur_tile, move_ready, busy, move_done);
        end
        model_tile = 0;
    endtask

    task automatic test_idle_ticks();
        repeat (3) begin
            tick();
            n_checks++;
            if (player_x !== 10'd72 || player_y !== 10'd56 || cur_tile !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_tick: x=%0d y=%0d tile=%0d busy=%b expected 72 56 0 0",
                         player_x, player_y, cur_tile, busy);
            end
        end
    endtask

    task automatic test_zero_cmd();
        issue(0, 1'b0);
        walk(0);
    endtask

    task automatic test_row_walk();
        issue(3, 1'b0);
        walk(3);
    endtask

    task automatic test_row_turn();
        issue(4, 1'b0);
        walk(4);
        n_checks++;
        if (player_x !== 10'd296 || player_y !== 10'd56 || cur_tile !== TW'(7)) begin
            n_fail++;
            $display("FAIL tile7_pos: x=%0d y=%0d tile=%0d expected 296 56 7", player_x, player_y, cur_tile);
        end
        issue(1, 1'b0);
        walk(1);
        n_checks++;
        if (player_x !== 10'd296 || player_y !== 10'd88 || cur_tile !== TW'(8)) begin
            n_fail++;
            $display("FAIL tile8_pos: x=%0d y=%0d tile=%0d expected 296 88 8", player_x, player_y, cur_tile);
        end
    endtask

    task automatic test_wrap();
        issue(15, 1'b0);
        walk(15);
        issue(7, 1'b0);
        walk(7);
        issue(3, 1'b0);
        walk(3);
        n_checks++;
        if (player_x !== 10'd104 || player_y !== 10'd56 || cur_tile !== TW'(1)) begin
            n_fail++;
            $display("FAIL wrap_final: x=%0d y=%0d tile=%0d expected 104 56 1", player_x, player_y, cur_tile);
        end
    endtask

    task automatic test_back_to_back();
        issue(2, 1'b1);
        walk(2);
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        walk(2);
    endtask

    task automatic test_reset_mid_move();
        issue(1, 1'b0);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (player_x !== 10'd72 || player_y !== 10'd56 || cur_tile !== '0 ||
            move_ready !== 1'b1 || busy !== 1'b0 || move_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_move: x=%0d y=%0d tile=%0d ready=%b busy=%b done=%b expected 72 56 0 1 0 0",
                     player_x, player_y, cur_tile, move_ready, busy, move_done);
        end
        @(negedge clk);
        reset = 1'b0;
        model_tile = 0;
        @(negedge clk);
        issue(1, 1'b0);
        walk(1);
    endtask

    task automatic test_random();
        int st;
        repeat (6) begin
            st = $urandom_range(0, 15);
            issue(st, 1'b0);
            walk(st);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_zero_cmd();
        test_row_walk();
        test_row_turn();
        test_wrap();
        test_back_to_back();
        test_reset_mid_move();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
